// File: rtl/instr_sequencer_pkg.sv
// Shared types and sizes for the instruction sequencer and its program memory.
// Instruction words are {opcode, operand}; the operand doubles as a jump target.
package instr_sequencer_pkg;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;
  localparam int INSTR_W = 8;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    OR   = 3'b011,
    JUMP = 3'b100,
    HALT = 3'b111
  } opcode_t;

  // The decoder treats this value as a no-op, so it is driven whenever nothing is issued.
  localparam logic [2:0] OPC_IDLE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    RESOLVE,
    DONE
  } seq_state_t;

  // The opcode field is a plain vector so that unassigned encodings pass through unchanged.
  typedef struct packed {
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
  } instr_t;

endpackage

// File: rtl/instr_sequencer_instr_rom.sv
// Program memory: one write port and one registered read port, contents not reset.
// A write and a read to the same address in one cycle return the new word.
module instr_rom
  import instr_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rdata_d;
  logic [INSTR_W-1:0] rdata_q;

  always_comb begin
    rdata_d = mem[raddr];
    if (we && (waddr == raddr)) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from program memory, issues one opcode per three cycles
// and resolves the next PC from the control unit's registered jmp_op.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               jmp_op,
  output logic [2:0]         opcode,
  output logic [ADDR_W-1:0]  operand,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] operand_q, operand_d;
  logic [2:0]        opcode_q, opcode_d;
  logic              instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] rom_rdata;
  logic              rom_we;
  instr_t            ir;

  // Reading at the next PC lets the fetched word sit in the read register during FETCH itself,
  // so the HALT/ISSUE decision costs no extra cycle.
  instr_rom u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_d),
    .rdata (rom_rdata)
  );

  assign ir     = instr_t'(rom_rdata);
  assign rom_we = prog_we && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      opcode_q      <= OPC_IDLE;
      operand_q     <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    opcode_d      = OPC_IDLE;
    operand_d     = operand_q;
    instr_valid_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (ir.opcode != HALT) begin
          state_d       = ISSUE;
          opcode_d      = ir.opcode;
          operand_d     = ir.operand;
          instr_valid_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      ISSUE: begin
        state_d = RESOLVE;
      end
      RESOLVE: begin
        pc_d    = jmp_op ? operand_q : pc_q + ADDR_W'(1);
        state_d = halt_req ? DONE : FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == FETCH) || (state_q == ISSUE) || (state_q == RESOLVE);
    done = (state_q == DONE);
  end

  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Closed-loop bench: a registered decoder model feeds jmp_op back, a program-level
// reference model predicts every issued instruction, and a monitor scores the DUT.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       halt_req;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic       jmp_op;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       instr_valid;
  logic [4:0] pc;
  logic       busy;
  logic       done;

  typedef struct {
    logic [2:0] opcode;
    logic [4:0] operand;
    logic [4:0] pc;
  } expIssue_t;

  expIssue_t  expQ[$];
  logic [7:0] modelMem [32];
  int         checkCount = 0;
  int         passCount = 0;
  int         issueSeen = 0;
  int         autoHaltAt = 0;
  bit         monitorOn = 1'b0;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .jmp_op      (jmp_op),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Control-unit stand-in: jmp_op is registered from the issued opcode.
  always @(posedge clk) begin
    if (rst) jmp_op <= 1'b0;
    else     jmp_op <= (opcode == 3'b100);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs starting just after a negedge, then releases them.
  task automatic applyStimulus(input logic st, input logic we, input logic [4:0] addr,
                               input logic [7:0] data);
    start = st; prog_we = we; prog_addr = addr; prog_data = data;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic writeWord(input int addr, input logic [7:0] data);
    modelMem[addr] = data;
    applyStimulus(1'b0, 1'b1, 5'(addr), data);
  endtask

  task automatic fillHalt();
    for (int a = 0; a < 32; a++) writeWord(a, 8'hE0);
  endtask

  // Program-level reference: walk the program, stopping at HALT or after maxIssues issues.
  task automatic buildExpect(input int maxIssues, output int finalPc, output int issues);
    int curPc;
    int op;
    int arg;
    int nextPc;
    expIssue_t e;
    curPc  = 0;
    issues = 0;
    finalPc = 0;
    while (1) begin
      op  = int'(modelMem[curPc][7:5]);
      arg = int'(modelMem[curPc][4:0]);
      if (op == 7) begin
        finalPc = curPc;
        return;
      end
      e.opcode = 3'(op); e.operand = 5'(arg); e.pc = 5'(curPc);
      expQ.push_back(e);
      issues++;
      nextPc = (op == 4) ? arg : (curPc + 1) % 32;
      if (issues == maxIssues) begin
        finalPc = nextPc;
        return;
      end
      curPc = nextPc;
    end
  endtask

  task automatic runProgram(input int maxIssues, input bit holdHalt, input bit busyWrite);
    int finalPc;
    int issues;
    bit seen;
    buildExpect(holdHalt ? 1 : maxIssues, finalPc, issues);
    autoHaltAt = (!holdHalt && issues == maxIssues) ? maxIssues : 0;
    issueSeen  = 0;
    halt_req   = holdHalt;
    applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    if (busyWrite) begin
      checkOutput("busy_during_run", int'(busy), 1);
      applyStimulus(1'b0, 1'b1, 5'd0, 8'hE0);
    end
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("run_done", int'(seen), 1);
    checkOutput("final_pc", int'(pc), finalPc);
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    expQ.delete();
    halt_req   = 1'b0;
    autoHaltAt = 0;
  endtask

  // Monitor: pops the scoreboard on every issue and checks the idle opcode otherwise.
  always @(negedge clk) begin
    expIssue_t e;
    if (monitorOn) begin
      if (instr_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_issue", int'(opcode), -1);
        end else begin
          e = expQ.pop_front();
          checkOutput("issue_opcode", int'(opcode), int'(e.opcode));
          checkOutput("issue_operand", int'(operand), int'(e.operand));
          checkOutput("issue_pc", int'(pc), int'(e.pc));
        end
        issueSeen++;
        if (autoHaltAt != 0 && issueSeen == autoHaltAt) halt_req = 1'b1;
      end else begin
        checkOutput("idle_opcode", int'(opcode), 7);
      end
    end
  end

  initial begin
    int opChoices [7];
    bit seen;
    opChoices = '{0, 1, 2, 3, 4, 4, 7};
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_opcode", int'(opcode), 7);
    checkOutput("reset_instr_valid", int'(instr_valid), 0);
    checkOutput("reset_pc", int'(pc), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst = 1'b0;
    monitorOn = 1'b1;

    $display("[TB] linear program");
    fillHalt();
    writeWord(0, 8'h00); writeWord(1, 8'h20); writeWord(2, 8'h60); writeWord(3, 8'hE0);
    runProgram(100, 1'b0, 1'b0);

    $display("[TB] jump program");
    fillHalt();
    writeWord(0, 8'h85); writeWord(5, 8'h40); writeWord(6, 8'hE0);
    runProgram(100, 1'b0, 1'b0);

    $display("[TB] wrap 31 -> 0");
    fillHalt();
    writeWord(0, 8'h9E); writeWord(30, 8'h23); writeWord(31, 8'h00);
    runProgram(3, 1'b0, 1'b0);

    $display("[TB] held halt_req and dropped busy write");
    fillHalt();
    writeWord(0, 8'h80);
    runProgram(1, 1'b1, 1'b1);
    runProgram(1, 1'b1, 1'b0);

    $display("[TB] reset during ISSUE");
    fillHalt();
    writeWord(0, 8'h00); writeWord(1, 8'h20); writeWord(2, 8'h60); writeWord(3, 8'hE0);
    expQ.push_back('{opcode: 3'b000, operand: 5'd0, pc: 5'd0});
    applyStimulus(1'b1, 1'b0, 5'd0, 8'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reached_issue", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_opcode", int'(opcode), 7);
    checkOutput("rst_mid_instr_valid", int'(instr_valid), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_pc", int'(pc), 0);
    rst = 1'b0;
    expQ.delete();
    runProgram(100, 1'b0, 1'b0);

    $display("[TB] random programs");
    for (int p = 0; p < 10; p++) begin
      for (int a = 0; a < 32; a++) begin
        writeWord(a, {3'(opChoices[$urandom_range(0, 6)]), 5'($urandom_range(0, 31))});
      end
      runProgram(int'($urandom_range(1, 30)), 1'b0, 1'b0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
